// File: rtl/ppu_sprite_eval.sv
// Per-scanline sprite range evaluator: scans all 128 OAM entries from a rotatable
// start index and collects up to 32 in-range sprite indices into the line list.
module ppu_sprite_eval (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  line,
  input  logic [2:0]  obj_size,
  input  logic [6:0]  first_sprite,
  output logic [6:0]  loam_addr,
  input  logic [15:0] loam_q,
  output logic [6:0]  hoam_addr,
  input  logic [1:0]  hoam_q,
  output logic        list_we,
  output logic [4:0]  list_idx,
  output logic [6:0]  list_data,
  output logic        busy,
  output logic        done,
  output logic        range_over,
  output logic [5:0]  count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t      state, state_next;
  logic [7:0]  line_r;
  logic [2:0]  size_r;
  logic [6:0]  issue_cnt;
  logic        eval_valid;
  logic [6:0]  eval_idx;
  logic [6:0]  w_dim, h_dim;
  logic [7:0]  dy;
  logic [8:0]  x_sum;
  logic        y_ok, x_ok, match, overflow, accept, last_issue;

  assign accept     = (state == IDLE) && start;
  assign last_issue = (issue_cnt == 7'd127);
  assign hoam_addr  = loam_addr;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

  always_comb begin
    w_dim = 7'd8;
    h_dim = 7'd8;
    case (size_r)
      3'd0: begin w_dim = hoam_q[1] ? 7'd16 : 7'd8;  h_dim = w_dim; end
      3'd1: begin w_dim = hoam_q[1] ? 7'd32 : 7'd8;  h_dim = w_dim; end
      3'd2: begin w_dim = hoam_q[1] ? 7'd64 : 7'd8;  h_dim = w_dim; end
      3'd3: begin w_dim = hoam_q[1] ? 7'd32 : 7'd16; h_dim = w_dim; end
      3'd4: begin w_dim = hoam_q[1] ? 7'd64 : 7'd16; h_dim = w_dim; end
      3'd5: begin w_dim = hoam_q[1] ? 7'd64 : 7'd32; h_dim = w_dim; end
      3'd6: begin w_dim = hoam_q[1] ? 7'd32 : 7'd16; h_dim = hoam_q[1] ? 7'd64 : 7'd32; end
      default: begin w_dim = hoam_q[1] ? 7'd32 : 7'd16; h_dim = 7'd32; end
    endcase
  end

  // A sprite with x8 set is on the line only if at least one pixel reaches
  // screen x >= 0, i.e. X + w > 256; X == 0 with x8 set is always accepted.
  always_comb begin
    dy       = line_r - loam_q[15:8];
    y_ok     = (dy < {1'b0, h_dim});
    x_sum    = {1'b0, loam_q[7:0]} + {2'b00, w_dim};
    x_ok     = !hoam_q[0] || (loam_q[7:0] == 8'd0) || (x_sum > 9'd256);
    match    = eval_valid && y_ok && x_ok;
    overflow = match && (count == 6'd32);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = SCAN;
      SCAN: begin
        if (overflow)        state_next = FINISH;
        else if (last_issue) state_next = DRAIN;
      end
      DRAIN:  if (overflow || !eval_valid) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_r     <= 8'd0;
      size_r     <= 3'd0;
      loam_addr  <= 7'd0;
      issue_cnt  <= 7'd0;
      eval_valid <= 1'b0;
      eval_idx   <= 7'd0;
      list_we    <= 1'b0;
      list_idx   <= 5'd0;
      list_data  <= 7'd0;
      range_over <= 1'b0;
      count      <= 6'd0;
    end else begin
      list_we    <= 1'b0;
      eval_valid <= (state == SCAN) && !overflow;
      eval_idx   <= loam_addr;
      if (accept) begin
        line_r     <= line;
        size_r     <= obj_size;
        loam_addr  <= first_sprite;
        issue_cnt  <= 7'd0;
        count      <= 6'd0;
        range_over <= 1'b0;
      end
      if (state == SCAN) begin
        issue_cnt <= issue_cnt + 7'd1;
        if (!last_issue && !overflow) loam_addr <= loam_addr + 7'd1;
      end
      if (match && (count < 6'd32)) begin
        list_we   <= 1'b1;
        list_idx  <= count[4:0];
        list_data <= eval_idx;
        count     <= count + 6'd1;
      end
      if (overflow) range_over <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_sprite_eval.sv
// Scoreboard bench for ppu_sprite_eval: a list-building reference model feeds
// expectation queues that a negedge monitor drains as the DUT responds.
module tb_ppu_sprite_eval;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  line = 8'd0;
  logic [2:0]  obj_size = 3'd0;
  logic [6:0]  first_sprite = 7'd0;
  logic [6:0]  loam_addr, hoam_addr;
  logic [15:0] loam_q;
  logic [1:0]  hoam_q;
  logic        list_we, busy, done, range_over;
  logic [4:0]  list_idx;
  logic [6:0]  list_data;
  logic [5:0]  count;

  ppu_sprite_eval dut (
    .clock(clock), .reset_n(reset_n), .start(start), .line(line),
    .obj_size(obj_size), .first_sprite(first_sprite),
    .loam_addr(loam_addr), .loam_q(loam_q), .hoam_addr(hoam_addr), .hoam_q(hoam_q),
    .list_we(list_we), .list_idx(list_idx), .list_data(list_data),
    .busy(busy), .done(done), .range_over(range_over), .count(count)
  );

  always #5 clock = ~clock;

  logic [7:0] oam_y [128];
  logic [7:0] oam_x [128];
  logic       oam_big [128];
  logic       oam_x8 [128];

  always @(posedge clock) begin
    loam_q <= {oam_y[loam_addr], oam_x[loam_addr]};
    hoam_q <= {oam_big[hoam_addr], oam_x8[hoam_addr]};
  end

  typedef struct {int slot; int sprite; int at_edge;} wr_t;
  typedef struct {int first; int start_edge; int done_cycle; int last_issue; int cnt; bit over;} scan_t;
  wr_t   wr_q[$];
  scan_t scan_q[$];

  int compared = 0;
  int mismatched = 0;
  int edge_count = 0;
  int cur_start = 0;
  int cur_done = 0;

  always @(posedge clock) edge_count++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_count);
    end
  endtask

  function automatic void dims(input int sel, input bit big, output int w, output int h);
    int sm_w[8] = '{8, 8, 8, 16, 16, 32, 16, 16};
    int sm_h[8] = '{8, 8, 8, 16, 16, 32, 32, 32};
    int lg_w[8] = '{16, 32, 64, 32, 64, 64, 32, 32};
    int lg_h[8] = '{16, 32, 64, 32, 64, 64, 64, 32};
    w = big ? lg_w[sel] : sm_w[sel];
    h = big ? lg_h[sel] : sm_h[sel];
  endfunction

  function automatic bit inRange(input int i, input int ln, input int sel);
    int w, h, dy;
    dims(sel, oam_big[i], w, h);
    dy = ((ln - int'(oam_y[i])) % 256 + 256) % 256;
    if (dy >= h) return 1'b0;
    if (!oam_x8[i]) return 1'b1;
    return (oam_x[i] == 8'd0) || (int'(oam_x[i]) + w > 256);
  endfunction

  // Drives a start (optionally preceded by an ignored start during the done
  // cycle) and records what the line list must look like.
  task automatic applyStimulus(input int first, input int ln, input int sel, input bit early);
    scan_t s;
    int n, p, i;
    if (early) begin
      start = 1'b1;
      line = 8'(ln ^ 8'h5A);
      obj_size = 3'(sel + 1);
      first_sprite = 7'(first + 33);
      @(posedge clock); #1;
    end
    start = 1'b1;
    line = 8'(ln);
    obj_size = 3'(sel);
    first_sprite = 7'(first);
    @(posedge clock); #1;
    start = 1'b0;
    line = 8'($urandom);
    obj_size = 3'($urandom);
    first_sprite = 7'($urandom);
    s.first = first;
    s.start_edge = edge_count;
    s.over = 1'b0;
    s.last_issue = 128;
    s.done_cycle = 131;
    n = 0;
    for (p = 0; p < 128; p++) begin
      i = (first + p) % 128;
      if (inRange(i, ln, sel)) begin
        if (n < 32) begin
          wr_q.push_back('{n, i, s.start_edge + p + 2});
          n++;
        end else begin
          s.over = 1'b1;
          s.done_cycle = p + 3;
          s.last_issue = (p + 2 > 128) ? 128 : p + 2;
          break;
        end
      end
    end
    s.cnt = n;
    scan_q.push_back(s);
    cur_start = s.start_edge;
    cur_done = s.done_cycle;
  endtask

  task automatic waitUntilCycle(input int c);
    while (edge_count - cur_start + 1 < c) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic pulseIgnored();
    start = 1'b1;
    first_sprite = 7'($urandom);
    line = 8'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (scan_q.size() != 0 && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    if (scan_q.size() != 0) begin
      checkOutput("scan timeout", scan_q.size(), 0);
      scan_q.delete();
      wr_q.delete();
    end
  endtask

  task automatic clearOam(input int ln);
    for (int i = 0; i < 128; i++) begin
      oam_y[i] = 8'(ln + 100);
      oam_x[i] = 8'($urandom);
      oam_big[i] = 1'b0;
      oam_x8[i] = 1'b0;
    end
  endtask

  task automatic randomOam(input int ln, input int density);
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 99) < density) oam_y[i] = 8'(ln - int'($urandom_range(0, 70)));
      else oam_y[i] = 8'($urandom);
      oam_x[i] = 8'($urandom);
      oam_big[i] = 1'($urandom);
      oam_x8[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (list_we) begin
        if (wr_q.size() == 0) checkOutput("unexpected list_we", 1, 0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          checkOutput("list_idx", int'(list_idx), e.slot);
          checkOutput("list_data", int'(list_data), e.sprite);
          checkOutput("list_we timing", edge_count, e.at_edge);
        end
      end
      if (scan_q.size() != 0) begin
        scan_t r;
        int cyc;
        r = scan_q[0];
        cyc = edge_count - r.start_edge + 1;
        checkOutput("busy", int'(busy), int'(cyc <= r.done_cycle));
        checkOutput("done", int'(done), int'(cyc == r.done_cycle));
        if (cyc <= r.last_issue) begin
          checkOutput("loam_addr", int'(loam_addr), (r.first + cyc - 1) % 128);
          checkOutput("hoam_addr", int'(hoam_addr), (r.first + cyc - 1) % 128);
        end
        if (cyc >= r.done_cycle) begin
          checkOutput("count", int'(count), r.cnt);
          checkOutput("range_over", int'(range_over), int'(r.over));
        end
        if (cyc > r.done_cycle) begin
          checkOutput("missing writes", wr_q.size(), 0);
          wr_q.delete();
          void'(scan_q.pop_front());
        end
      end else begin
        checkOutput("idle busy", int'(busy), 0);
        checkOutput("idle done", int'(done), 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      oam_y[i] = 8'hF0; oam_x[i] = 8'd0; oam_big[i] = 1'b0; oam_x8[i] = 1'b0;
    end
    #12;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset loam_addr", int'(loam_addr), 0);
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset list_we", int'(list_we), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] no matching sprites");
    for (int i = 0; i < 128; i++) oam_x[i] = 8'($urandom);
    applyStimulus(0, 10, 0, 1'b0);
    waitIdle();

    $display("[TB] rotation and wrap");
    clearOam(10);
    oam_y[5] = 8'd10;
    oam_y[100] = 8'd10;
    applyStimulus(100, 10, 0, 1'b0);
    waitIdle();

    $display("[TB] size boundaries");
    clearOam(73);
    oam_y[3] = 8'd10; oam_big[3] = 1'b1;
    applyStimulus(0, 73, 5, 1'b0);
    waitIdle();
    clearOam(74);
    oam_y[3] = 8'd10; oam_big[3] = 1'b1;
    applyStimulus(0, 74, 5, 1'b0);
    waitIdle();
    clearOam(42);
    oam_y[3] = 8'd10; oam_big[3] = 1'b0;
    applyStimulus(0, 42, 5, 1'b0);
    waitIdle();

    $display("[TB] x rule");
    clearOam(20);
    for (int i = 0; i < 4; i++) oam_y[i] = 8'd20;
    oam_x8[0] = 1'b1; oam_x[0] = 8'h00;
    oam_x8[1] = 1'b1; oam_x[1] = 8'hF9;
    oam_x8[2] = 1'b1; oam_x[2] = 8'hF8;
    oam_x8[3] = 1'b0; oam_x[3] = 8'hF8;
    applyStimulus(0, 20, 0, 1'b0);
    waitIdle();

    $display("[TB] overflow");
    clearOam(30);
    for (int i = 0; i < 40; i++) oam_y[i] = 8'd30;
    applyStimulus(0, 30, 0, 1'b0);
    waitIdle();

    $display("[TB] reset mid-scan");
    randomOam(60, 20);
    applyStimulus(7, 60, 2, 1'b0);
    waitUntilCycle(50);
    reset_n = 1'b0;
    #1;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort list_we", int'(list_we), 0);
    checkOutput("abort count", int'(count), 0);
    checkOutput("abort range_over", int'(range_over), 0);
    checkOutput("abort loam_addr", int'(loam_addr), 0);
    checkOutput("abort list_idx", int'(list_idx), 0);
    checkOutput("abort list_data", int'(list_data), 0);
    scan_q.delete();
    wr_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    applyStimulus(7, 60, 2, 1'b0);
    waitIdle();

    $display("[TB] randomized lines with chained starts");
    for (int t = 0; t < 12; t++) begin
      int ln, sel, first;
      ln = $urandom_range(0, 255);
      sel = $urandom_range(0, 7);
      first = $urandom_range(0, 127);
      randomOam(ln, $urandom_range(5, 45));
      applyStimulus(first, ln, sel, 1'b0);
      waitUntilCycle(20);
      if (cur_done > 21) pulseIgnored();
      if (t % 3 == 2) begin
        waitUntilCycle(cur_done);
        applyStimulus($urandom_range(0, 127), ln, $urandom_range(0, 7), 1'b1);
      end
      waitIdle();
    end

    repeat (4) begin @(posedge clock); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
